mem_host_sequencer: RTL and testbench

Host-side initiator for the external memory port of the CPU top level, i.e. the agent that drives `address`/`mem_en`/`read_write`/`data_in`/`clr_mem`/`cpu_en` and consumes `read_out_data`. On a `start` pulse it optionally clears memory and streams a program image into memory over a valid/ready input. It then enables the CPU for a programmed number of cycles and streams a window of memory back out over a valid/ready output. It sits between the testbench or host link and the CPU top, and is the only driver of that port.

---
 rtl/mem_host_sequencer.sv | 136 +++++++++++++
 tb/tb_mem_host_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_host_sequencer.sv
// Host-side sequencer for the CPU memory port: optional clear, streamed program load,
// timed CPU run window, then streamed dump of a memory window.
module mem_host_sequencer #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int RUN_W  = 16
) (
    input  logic              main_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              do_clear,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W-1:0] load_count,
    input  logic [RUN_W-1:0]  run_cycles,
    input  logic [ADDR_W-1:0] dump_base,
    input  logic [ADDR_W-1:0] dump_count,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              dump_valid,
    output logic [DATA_W-1:0] dump_data,
    input  logic              dump_ready,
    output logic              cpu_en,
    output logic              mem_en,
    output logic              read_write,
    output logic              clr_mem,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] read_out_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_RUN, S_DUMP_RD, S_DUMP_CAP, S_DUMP_OUT, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
    localparam logic [RUN_W-1:0]  R_ONE = RUN_W'(1);

    state_t            state, nxt;
    logic [ADDR_W-1:0] lb_q, lc_q, db_q, dc_q;
    logic [RUN_W-1:0]  rc_q, run_left, run_load;
    logic [ADDR_W-1:0] i_cnt, j_cnt, rd_addr;
    logic              accept, last_beat, last_word;

    function automatic state_t first_step(input logic [ADDR_W-1:0] lc,
                                          input logic [RUN_W-1:0]  rc,
                                          input logic [ADDR_W-1:0] dc);
        if (lc != '0)      return S_LOAD;
        else if (rc != '0) return S_RUN;
        else if (dc != '0) return S_DUMP_RD;
        else               return S_DONE;
    endfunction

    always_comb begin
        accept    = (state == S_LOAD) && ld_ready && ld_valid;
        last_beat = (i_cnt == lc_q - A_ONE);
        last_word = (j_cnt == dc_q - A_ONE);
        run_load  = (state == S_IDLE) ? run_cycles : rc_q;
        rd_addr   = db_q;
        if (state == S_IDLE)          rd_addr = dump_base;
        else if (state == S_DUMP_OUT) rd_addr = db_q + j_cnt + A_ONE;

        nxt = state;
        case (state)
            S_IDLE:
                if (start) nxt = do_clear ? S_CLEAR : first_step(load_count, run_cycles, dump_count);
            S_CLEAR:    nxt = first_step(lc_q, rc_q, dc_q);
            // ld_ready low inside LOAD marks the cycle carrying the final write
            S_LOAD:     if (!ld_ready) nxt = first_step('0, rc_q, dc_q);
            S_RUN:      if (run_left == '0) nxt = first_step('0, '0, dc_q);
            S_DUMP_RD:  nxt = S_DUMP_CAP;
            S_DUMP_CAP: nxt = S_DUMP_OUT;
            S_DUMP_OUT: if (dump_ready) nxt = last_word ? S_DONE : S_DUMP_RD;
            S_DONE:     nxt = S_IDLE;
            default:    nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each step's drive appears with the step.
    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            cpu_en     <= 1'b0;
            clr_mem    <= 1'b0;
            mem_en     <= 1'b0;
            read_write <= 1'b0;
            address    <= '0;
            data_in    <= '0;
            ld_ready   <= 1'b0;
            dump_valid <= 1'b0;
            dump_data  <= '0;
            lb_q       <= '0;
            lc_q       <= '0;
            db_q       <= '0;
            dc_q       <= '0;
            rc_q       <= '0;
            run_left   <= '0;
            i_cnt      <= '0;
            j_cnt      <= '0;
        end else begin
            state      <= nxt;
            busy       <= (nxt != S_IDLE);
            done       <= (nxt == S_DONE);
            cpu_en     <= (nxt == S_RUN);
            clr_mem    <= (nxt == S_CLEAR);
            mem_en     <= (nxt == S_CLEAR) || (nxt == S_DUMP_RD) || accept;
            read_write <= accept;
            address    <= accept ? (lb_q + i_cnt) : ((nxt == S_DUMP_RD) ? rd_addr : '0);
            data_in    <= accept ? ld_data : '0;
            ld_ready   <= (nxt == S_LOAD) &&
                          ((state != S_LOAD) || (ld_ready && !(accept && last_beat)));
            dump_valid <= (nxt == S_DUMP_OUT);
            if (state == S_DUMP_CAP) dump_data <= read_out_data;

            if (state == S_IDLE && start) begin
                lb_q  <= load_base;
                lc_q  <= load_count;
                db_q  <= dump_base;
                dc_q  <= dump_count;
                rc_q  <= run_cycles;
                i_cnt <= '0;
                j_cnt <= '0;
            end
            if (accept) i_cnt <= i_cnt + A_ONE;
            if (state == S_DUMP_OUT && dump_ready) j_cnt <= j_cnt + A_ONE;

            if (nxt == S_RUN && state != S_RUN) run_left <= run_load - R_ONE;
            else if (state == S_RUN)            run_left <= run_left - R_ONE;
        end
    end

endmodule

// File: tb/tb_mem_host_sequencer.sv
// Directed bench for mem_host_sequencer with a synchronous memory model and a toy CPU store.
module tb_mem_host_sequencer;

    logic        main_clk = 1'b0;
    logic        reset;
    logic        start, do_clear;
    logic [11:0] load_base, load_count, dump_base, dump_count;
    logic [15:0] run_cycles;
    logic        ld_valid, ld_ready, dump_valid, dump_ready;
    logic [31:0] ld_data, dump_data, data_in, read_out_data;
    logic        cpu_en, mem_en, read_write, clr_mem, busy, done;
    logic [11:0] address;

    int total = 0;
    int bad   = 0;

    mem_host_sequencer #(.ADDR_W(12), .DATA_W(32), .RUN_W(16)) dut (
        .main_clk(main_clk), .reset(reset), .start(start), .do_clear(do_clear),
        .load_base(load_base), .load_count(load_count), .run_cycles(run_cycles),
        .dump_base(dump_base), .dump_count(dump_count),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .dump_valid(dump_valid), .dump_data(dump_data), .dump_ready(dump_ready),
        .cpu_en(cpu_en), .mem_en(mem_en), .read_write(read_write), .clr_mem(clr_mem),
        .address(address), .data_in(data_in), .read_out_data(read_out_data),
        .busy(busy), .done(done)
    );

    always #5 main_clk = ~main_clk;

    // Synchronous memory; the "CPU" stores 0x5 at 0x100 in its third enabled cycle.
    logic [31:0] mem [0:4095];
    int          cpu_k = 0;
    always @(posedge main_clk) begin
        if (mem_en) begin
            if (clr_mem) for (int a = 0; a < 4096; a++) mem[a] <= '0;
            else if (read_write) mem[address] <= data_in;
            else read_out_data <= mem[address];
        end
        if (cpu_en) begin
            cpu_k <= cpu_k + 1;
            if (cpu_k == 2) mem[12'h100] <= 32'h5;
        end else begin
            cpu_k <= 0;
        end
    end

    // Port monitor, sampled mid-cycle; counters are cumulative.
    int          cyc = 0, n_clr = 0, n_wr = 0, n_rd = 0, n_cpu = 0, n_done = 0, n_busy = 0;
    int          last_rd_cyc = 0, last_cpu_cyc = 0, run_len = 0, last_run = 0, rd_to_valid = 0;
    logic        prev_dv = 1'b0;
    logic [11:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    int          wr_cyc  [0:63];
    always @(negedge main_clk) begin
        cyc++;
        if (mem_en && clr_mem) n_clr++;
        if (mem_en && read_write) begin
            wr_addr[n_wr % 64] = address;
            wr_data[n_wr % 64] = data_in;
            wr_cyc[n_wr % 64]  = cyc;
            n_wr++;
        end
        if (mem_en && !read_write && !clr_mem) begin n_rd++; last_rd_cyc = cyc; end
        if (cpu_en) begin n_cpu++; last_cpu_cyc = cyc; run_len++; end
        else if (run_len != 0) begin last_run = run_len; run_len = 0; end
        if (dump_valid && !prev_dv) rd_to_valid = cyc - last_rd_cyc;
        prev_dv = dump_valid;
        if (done) n_done++;
        if (busy) n_busy++;
    end

    logic [31:0] ld_vec   [0:15];
    logic [31:0] dump_got [0:15];
    int          n_got;
    int          s_clr, s_wr, s_rd, s_cpu, s_done, s_busy;

    task automatic tick;
        @(posedge main_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap;
        s_clr = n_clr; s_wr = n_wr; s_rd = n_rd; s_cpu = n_cpu; s_done = n_done; s_busy = n_busy;
    endtask

    // One sequence: config, start pulse, then feed/consume streams until the done pulse.
    task automatic run_seq(input string nm, input logic clr,
                           input logic [11:0] lb, input logic [11:0] lc, input logic [15:0] rc,
                           input logic [11:0] db, input logic [11:0] dc,
                           input int gap_mod, input int stall_word, input int ign_cyc,
                           input logic [3:0] first);
        int          cnt = 0, stall = 0, ld_idx = 0;
        logic        fin = 1'b0, acc_ld, acc_d;
        logic [31:0] held = '0, dv_before;
        snap();
        n_got = 0;
        do_clear = clr; load_base = lb; load_count = lc; run_cycles = rc;
        dump_base = db; dump_count = dc;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({nm, "_busy_k1"}, {31'b0, busy}, 32'd1);
        chk({nm, "_first_step"}, {28'b0, mem_en, clr_mem, ld_ready, cpu_en}, {28'b0, first});
        // scrambled config must have no effect on the running sequence
        do_clear = ~clr; load_base = ~lb; load_count = 12'h7; run_cycles = 16'h3;
        dump_base = ~db; dump_count = 12'h9;
        while (!fin && cnt < 500) begin
            ld_valid = (ld_idx < int'(lc)) && (gap_mod == 0 || (cnt % gap_mod) != 1);
            ld_data  = (ld_idx < 16) ? ld_vec[ld_idx] : '0;
            dump_ready = !(n_got == stall_word && stall < 5);
            if (dump_valid && !dump_ready) begin
                if (stall > 0) chk({nm, "_dump_hold"}, dump_data, held);
                held = dump_data;
                stall++;
            end
            start  = (cnt == ign_cyc);
            acc_ld = ld_valid && ld_ready;
            acc_d  = dump_valid && dump_ready;
            dv_before = dump_data;
            fin    = done;
            tick();
            start = 1'b0;
            if (acc_ld) ld_idx++;
            if (acc_d) begin
                if (n_got < 16) dump_got[n_got] = dv_before;
                n_got++;
            end
            cnt++;
        end
        ld_valid = 1'b0;
        dump_ready = 1'b0;
        chk({nm, "_finished"}, {31'b0, fin}, 32'd1);
        chk({nm, "_done_count"}, n_done - s_done, 32'd1);
        chk({nm, "_idle_after"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; do_clear = 1'b0;
        load_base = '0; load_count = '0; run_cycles = '0; dump_base = '0; dump_count = '0;
        ld_valid = 1'b0; ld_data = '0; dump_ready = 1'b0;
        tick(); tick();
        chk("reset_ctrl", {24'b0, busy, done, cpu_en, mem_en, read_write, clr_mem, ld_ready, dump_valid}, 32'd0);
        chk("reset_addr", {20'b0, address}, 32'd0);
        chk("reset_data", data_in | dump_data, 32'd0);
        reset = 1'b0;
        tick();

        // Seed a word the upcoming clear must wipe
        ld_vec[0] = 32'hDEAD_BEEF;
        run_seq("seed", 1'b0, 12'h014, 12'd1, 16'd0, 12'h000, 12'd0, 0, -1, -1, 4'b0010);
        chk("seed_wr", {20'b0, wr_addr[s_wr % 64]}, 32'h014);

        // Round trip with clear, load gaps, and a 5-cycle stall on word 2
        for (int k = 0; k < 4; k++) ld_vec[k] = 32'hA0 + k;
        run_seq("rt", 1'b1, 12'h010, 12'd4, 16'd0, 12'h010, 12'd5, 2, 2, -1, 4'b1100);
        chk("rt_clr_count", n_clr - s_clr, 32'd1);
        chk("rt_wr_count", n_wr - s_wr, 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("rt_wr_addr", {20'b0, wr_addr[(s_wr + k) % 64]}, 32'h010 + k);
            chk("rt_wr_data", wr_data[(s_wr + k) % 64], 32'hA0 + k);
        end
        chk("rt_rd_count", n_rd - s_rd, 32'd5);
        chk("rt_dump_count", n_got, 32'd5);
        for (int k = 0; k < 4; k++) chk("rt_dump_data", dump_got[k], 32'hA0 + k);
        chk("rt_cleared_word", dump_got[4], 32'h0);
        chk("rt_rd_to_valid", rd_to_valid, 32'd2);

        // Address wrap, full-rate load, ignored start during LOAD
        ld_vec[0] = 32'h11; ld_vec[1] = 32'h22; ld_vec[2] = 32'h33; ld_vec[3] = 32'h44;
        run_seq("wrap", 1'b0, 12'hFFE, 12'd4, 16'd0, 12'hFFE, 12'd4, 0, -1, 1, 4'b0010);
        chk("wrap_clr_count", n_clr - s_clr, 32'd0);
        chk("wrap_wr_count", n_wr - s_wr, 32'd4);
        chk("wrap_wr_a0", {20'b0, wr_addr[(s_wr + 0) % 64]}, 32'hFFE);
        chk("wrap_wr_a1", {20'b0, wr_addr[(s_wr + 1) % 64]}, 32'hFFF);
        chk("wrap_wr_a2", {20'b0, wr_addr[(s_wr + 2) % 64]}, 32'h000);
        chk("wrap_wr_a3", {20'b0, wr_addr[(s_wr + 3) % 64]}, 32'h001);
        chk("wrap_throughput", wr_cyc[(s_wr + 3) % 64] - wr_cyc[s_wr % 64], 32'd3);
        chk("wrap_dump_count", n_got, 32'd4);
        for (int k = 0; k < 4; k++) chk("wrap_dump_data", dump_got[k], ld_vec[k]);

        // Run window followed by a single-word dump of the CPU's store
        run_seq("run", 1'b0, 12'h000, 12'd0, 16'd10, 12'h100, 12'd1, 0, -1, -1, 4'b0001);
        chk("run_cpu_cycles", n_cpu - s_cpu, 32'd10);
        chk("run_consecutive", last_run, 32'd10);
        chk("run_rd_follows", last_rd_cyc - last_cpu_cyc, 32'd1);
        chk("run_dump_data", dump_got[0], 32'h5);

        // All-zero config, with start held on the done cycle
        run_seq("zero", 1'b0, 12'h000, 12'd0, 16'd0, 12'h000, 12'd0, 0, -1, 0, 4'b0000);
        chk("zero_busy_cycles", n_busy - s_busy, 32'd1);
        chk("zero_no_write", n_wr - s_wr, 32'd0);
        tick();
        chk("zero_start_on_done", {31'b0, busy}, 32'd0);

        // Reset asserted mid-RUN drops cpu_en without waiting for a clock edge
        do_clear = 1'b0; load_count = '0; dump_count = '0; run_cycles = 16'd20;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("mid_run_cpu_en", {31'b0, cpu_en}, 32'd1);
        #3 reset = 1'b1;
        #1;
        chk("async_rst_cpu_en", {31'b0, cpu_en}, 32'd0);
        chk("async_rst_ctrl", {24'b0, busy, done, cpu_en, mem_en, read_write, clr_mem, ld_ready, dump_valid}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_idle", {31'b0, busy}, 32'd0);
        run_seq("after_rst", 1'b0, 12'h000, 12'd0, 16'd2, 12'h010, 12'd1, 0, -1, -1, 4'b0001);
        chk("after_rst_dump", dump_got[0], 32'hA0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
